// File: rtl/boron_pkg.sv
// ---------------------------------------------------------------------------
// boron_pkg
// Shared definitions for the BORON round-datapath controller: block, key and
// round-count widths, the index of the final round, and the controller state
// encoding.
// ---------------------------------------------------------------------------
package boron_pkg;

    localparam int BLK_W            = 64;   // plaintext / ciphertext width
    localparam int KEY_W            = 128;  // key width
    localparam int CNT_W            = 5;    // datapath round count width
    localparam int BORON_LAST_ROUND = 24;   // count value that yields the ciphertext

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_CAPT = 3'd3,
        ST_HOLD = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/boron_out_buf.sv
// ---------------------------------------------------------------------------
// boron_out_buf
// One-entry valid/ready holding register for the ciphertext. A load captures
// din and raises out_valid; the entry is released on out_valid && out_ready.
// dout keeps its last value after release.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   load                 capture din into the buffer this cycle
//   din       [W]        data to capture
//   out_ready            consumer accepts the held entry
//   out_valid            buffer holds an unconsumed entry
//   dout      [W]        held data
// ---------------------------------------------------------------------------
module boron_out_buf
    import boron_pkg::*;
#(
    parameter int W = BLK_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] dout
);

    // NOTE: the data register is reset as well, because the ciphertext output
    // must read zero after reset; a pure holding register would not need it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            dout      <= din;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/boron_ctrl.sv
// ---------------------------------------------------------------------------
// boron_ctrl
// Upstream/downstream controller for the BORON round datapath. Accepts a
// plaintext/key pair over valid/ready, resets the datapath round counter,
// loads the plaintext, lets the datapath run until its count reaches ROUNDS,
// then captures the ciphertext into a one-entry output buffer.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_pt [64], in_key [128]
//   core_pt, core_key     operands to the datapath, held until the next accept
//   core_sel              1 = datapath loads plaintext
//   core_rst              active-high datapath round-counter reset
//   core_count [CNT_W]    datapath round count
//   core_ct    [64]       datapath ciphertext
//   out_valid/out_ready   ciphertext handshake; out_ct [64]
//   busy                  controller not in IDLE
//   err                   (BORON_CTRL_TIMEOUT_EN only) one-cycle RUN-timeout pulse
//
// Build option: define BORON_CTRL_TIMEOUT_EN to add the RUN watchdog
// (parameter TIMEOUT, output err). Without it RUN only exits on count match.
// ---------------------------------------------------------------------------
module boron_ctrl
    import boron_pkg::*;
#(
    parameter int ROUNDS  = BORON_LAST_ROUND,
    parameter int CNT_W   = boron_pkg::CNT_W
`ifdef BORON_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 40
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_pt,
    input  logic [KEY_W-1:0] in_key,
    output logic [BLK_W-1:0] core_pt,
    output logic [KEY_W-1:0] core_key,
    output logic             core_sel,
    output logic             core_rst,
    input  logic [CNT_W-1:0] core_count,
    input  logic [BLK_W-1:0] core_ct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_ct,
    output logic             busy
`ifdef BORON_CTRL_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    ctrl_state_t state, state_nxt;
    logic        accept;
    logic        count_hit;
    logic        buf_load;

    // A request is taken only in IDLE with the output buffer empty, so a new
    // run can never overwrite an unconsumed ciphertext.
    assign accept    = (state == ST_IDLE) && in_valid && !out_valid;
    assign count_hit = (core_count == CNT_W'(ROUNDS));
    assign busy      = (state != ST_IDLE);

`ifdef BORON_CTRL_TIMEOUT_EN
    localparam int CYC_W = $clog2(TIMEOUT + 1);

    logic [CYC_W-1:0] run_cyc;
    logic             timeout_hit;

    // run_cyc counts completed RUN cycles; the abort fires on the RUN cycle
    // that brings it to TIMEOUT. A count match on that same cycle wins.
    assign timeout_hit = (state == ST_RUN) && !count_hit &&
                         (run_cyc == CYC_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cyc <= '0;
            err     <= 1'b0;
        end else begin
            err <= timeout_hit;
            if (state == ST_LOAD) begin
                run_cyc <= '0;
            end else if (state == ST_RUN) begin
                run_cyc <= run_cyc + CYC_W'(1);
            end
        end
    end
`endif

    // NOTE: state and operand registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            core_pt  <= '0;
            core_key <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                core_pt  <= in_pt;
                core_key <= in_key;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        core_sel  = 1'b0;
        core_rst  = 1'b0;
        buf_load  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = !out_valid;
                core_rst = 1'b1;
                if (accept) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                core_sel  = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (count_hit) begin
                    state_nxt = ST_CAPT;
                end
`ifdef BORON_CTRL_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                    core_rst  = 1'b1;
                end
`endif
            end
            // The datapath ciphertext register settles during this cycle.
            ST_CAPT: state_nxt = ST_HOLD;
            ST_HOLD: begin
                core_rst  = 1'b1;
                buf_load  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    boron_out_buf #(.W(BLK_W)) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .din       (core_ct),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (out_ct)
    );

endmodule
